// File: rtl/mac_core_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mac_core_pkg                                                 |
// | Description : Shared types and helpers for the mac_core requester arbiter. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mac_core_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    DRAIN  = 2'd2,
    RESULT = 2'd3
  } state_e;

  localparam int C_DATA_W_DEF = 32;
  localparam int C_ACC_W_DEF  = 64;

  typedef logic signed [C_DATA_W_DEF-1:0] operand_t;
  typedef logic signed [C_ACC_W_DEF-1:0]  acc_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Signed add overflow from the sign bits of both addends and the sum.
  function automatic logic add_ovf(input logic a_sign, input logic b_sign, input logic sum_sign);
    return (a_sign == b_sign) && (sum_sign != a_sign);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mac_core_mul_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mac_core_mul_pipe                                            |
// | Description : MULT_LAT-stage signed multiplier with a valid shift register.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mac_core_mul_pipe #(
  parameter int DATA_W   = 32,
  parameter int MULT_LAT = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       valid_i,
  input  logic signed [DATA_W-1:0]   a_i,
  input  logic signed [DATA_W-1:0]   b_i,
  output logic                       valid_o,
  output logic signed [2*DATA_W-1:0] product_o
);

  logic [MULT_LAT-1:0]         valid_q;
  logic signed [2*DATA_W-1:0]  prod_q [MULT_LAT];
  logic signed [2*DATA_W-1:0]  w_a_ext;
  logic signed [2*DATA_W-1:0]  w_b_ext;
  logic signed [2*DATA_W-1:0]  w_prod;

  // Sign-extend first so the truncated product is the exact full-width result.
  assign w_a_ext = (2*DATA_W)'(a_i);
  assign w_b_ext = (2*DATA_W)'(b_i);
  assign w_prod  = w_a_ext * w_b_ext;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= valid_i;
      for (int k = 1; k < MULT_LAT; k++) begin
        valid_q[k] <= valid_q[k-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    prod_q[0] <= w_prod;
    for (int k = 1; k < MULT_LAT; k++) begin
      prod_q[k] <= prod_q[k-1];
    end
  end

  assign valid_o   = valid_q[MULT_LAT-1];
  assign product_o = prod_q[MULT_LAT-1];

endmodule
`default_nettype wire

// File: rtl/mac_core_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mac_core_arbiter                                             |
// | Description : Round-robin arbiter sharing one signed MAC between requesters|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mac_core_arbiter
  import mac_core_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 32,
  parameter int ACC_W    = 64,
  parameter int MULT_LAT = 2,
  parameter int CNT_W    = 16
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic                           enable,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]      req_a,
  input  logic [NUM_REQ*DATA_W-1:0]      req_b,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [ACC_W-1:0]               res_data,
  output logic [id_width(NUM_REQ)-1:0]   res_id,
  output logic [CNT_W-1:0]               res_count,
  output logic                           res_ovf,
  output logic                           busy
);

  localparam int             ID_W  = id_width(NUM_REQ);
  localparam int             INF_W = $clog2(MULT_LAT + 1);
  localparam logic [ID_W:0]  C_NUM = (ID_W + 1)'(NUM_REQ);

  state_e                     state_q, state_d;
  logic [ID_W-1:0]            grant_q, grant_d;
  logic [ID_W-1:0]            rr_q, rr_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic                       ovf_q, ovf_d;
  logic [INF_W-1:0]           inflight_q, inflight_d;
  logic [ACC_W-1:0]           res_data_q, res_data_d;
  logic [ID_W-1:0]            res_id_q, res_id_d;
  logic [CNT_W-1:0]           res_count_q, res_count_d;
  logic                       res_ovf_q, res_ovf_d;

  logic                       w_found;
  logic [ID_W-1:0]            w_gsel;
  logic [ID_W-1:0]            w_cand;
  logic [ID_W:0]              w_dist, w_best;
  logic signed [DATA_W-1:0]   w_a, w_b;
  logic                       w_vg, w_last, w_accept;
  logic                       w_pv;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext, w_sum;

  // Pick the valid requester closest (upward, modulo NUM_REQ) to the rr pointer.
  always_comb begin
    w_found = 1'b0;
    w_gsel  = rr_q;
    w_cand  = '0;
    w_dist  = '0;
    w_best  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_cand = ID_W'(i);
      w_dist = (w_cand >= rr_q) ? ({1'b0, w_cand} - {1'b0, rr_q})
                                : ({1'b0, w_cand} + C_NUM - {1'b0, rr_q});
      if (req_valid[i] && (!w_found || (w_dist < w_best))) begin
        w_found = 1'b1;
        w_gsel  = w_cand;
        w_best  = w_dist;
      end
    end
  end

  always_comb begin
    w_a    = '0;
    w_b    = '0;
    w_vg   = 1'b0;
    w_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == ID_W'(i)) begin
        w_a    = req_a[i*DATA_W +: DATA_W];
        w_b    = req_b[i*DATA_W +: DATA_W];
        w_vg   = req_valid[i];
        w_last = req_last[i];
      end
    end
  end

  assign w_accept = (state_q == BUSY) && w_vg;

  mac_core_mul_pipe #(
    .DATA_W   (DATA_W),
    .MULT_LAT (MULT_LAT)
  ) u_mul_pipe (
    .clk_i     (ACLK),
    .rst_i     (ARESET),
    .valid_i   (w_accept),
    .a_i       (w_a),
    .b_i       (w_b),
    .valid_o   (w_pv),
    .product_o (w_prod)
  );

  assign w_prod_ext = ACC_W'(w_prod);
  assign w_sum      = acc_q + w_prod_ext;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    acc_d       = acc_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    inflight_d  = inflight_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    res_count_d = res_count_q;
    res_ovf_d   = res_ovf_q;

    if (w_pv) begin
      acc_d = w_sum;
      ovf_d = ovf_q | add_ovf(acc_q[ACC_W-1], w_prod_ext[ACC_W-1], w_sum[ACC_W-1]);
    end
    if (w_accept && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
    case ({w_accept, w_pv})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase

    case (state_q)
      IDLE: begin
        if (enable && w_found) begin
          grant_d = w_gsel;
          rr_d    = (w_gsel == ID_W'(NUM_REQ - 1)) ? '0 : w_gsel + 1'b1;
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (w_accept && w_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The final product is being folded in this cycle when inflight_d reaches zero.
        if (inflight_d == '0) begin
          res_data_d  = acc_d;
          res_id_d    = grant_q;
          res_count_d = count_q;
          res_ovf_d   = ovf_d;
          state_d     = RESULT;
        end
      end
      RESULT: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_q        <= '0;
      acc_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      inflight_q  <= '0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      res_count_q <= '0;
      res_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      inflight_q  <= inflight_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      res_count_q <= res_count_d;
      res_ovf_q   <= res_ovf_d;
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == BUSY) begin
      req_ready = NUM_REQ'(1) << grant_q;
    end
  end

  assign res_valid = (state_q == RESULT);
  assign busy      = (state_q != IDLE);
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign res_count = res_count_q;
  assign res_ovf   = res_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_core_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mac_core_arbiter                                          |
// | Description : Directed plus randomized bench with a behavioural MAC model. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mac_core_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int DATA_W   = 32;
  localparam int ACC_W    = 64;
  localparam int MULT_LAT = 2;
  localparam int CNT_W    = 16;
  localparam int ID_W     = 2;

  logic                      ACLK = 1'b0;
  logic                      ARESET;
  logic                      enable;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ-1:0]        req_last;
  logic                      res_valid;
  logic                      res_ready;
  logic [ACC_W-1:0]          res_data;
  logic [ID_W-1:0]           res_id;
  logic [CNT_W-1:0]          res_count;
  logic                      res_ovf;
  logic                      busy;

  mac_core_arbiter #(
    .NUM_REQ (NUM_REQ), .DATA_W (DATA_W), .ACC_W (ACC_W),
    .MULT_LAT (MULT_LAT), .CNT_W (CNT_W)
  ) dut (
    .ACLK (ACLK), .ARESET (ARESET), .enable (enable),
    .req_valid (req_valid), .req_ready (req_ready),
    .req_a (req_a), .req_b (req_b), .req_last (req_last),
    .res_valid (res_valid), .res_ready (res_ready),
    .res_data (res_data), .res_id (res_id), .res_count (res_count),
    .res_ovf (res_ovf), .busy (busy)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;
  int model_rr = 0;
  int qa[$];
  int qb[$];
  logic signed [63:0] exp_sum;
  logic               exp_ovf;
  int                 exp_cnt;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: exact 64-bit products summed with wrap, overflow judged per addition.
  task automatic model_compute();
    longint p;
    logic signed [63:0] s;
    exp_sum = '0;
    exp_ovf = 1'b0;
    for (int i = 0; i < qa.size(); i++) begin
      p = longint'(qa[i]) * longint'(qb[i]);
      s = exp_sum + p;
      if ((exp_sum[63] == p[63]) && (s[63] != exp_sum[63])) exp_ovf = 1'b1;
      exp_sum = s;
    end
    exp_cnt = qa.size();
  endtask

  function automatic int model_grant(input logic [NUM_REQ-1:0] v);
    int idx;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (model_rr + k) % NUM_REQ;
      if (v[idx[ID_W-1:0]]) return idx;
    end
    return -1;
  endfunction

  task automatic do_reset();
    ARESET = 1'b1;
    tick();
    tick();
    check("rst_req_ready", req_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_id", res_id, 0);
    check("rst_res_count", res_count, 0);
    check("rst_res_ovf", res_ovf, 0);
    check("rst_busy", busy, 0);
    ARESET = 1'b0;
    model_rr = 0;
  endtask

  task automatic send_vec(input int id, input int max_gap);
    logic [ID_W-1:0]    sid;
    logic [NUM_REQ-1:0] onehot;
    int n;
    int exp_g;
    sid = id[ID_W-1:0];
    exp_g = 0;
    model_compute();
    for (int i = 0; i < qa.size(); i++) begin
      if (i > 0 && max_gap > 0) begin
        req_valid[sid] = 1'b0;
        repeat ($urandom_range(0, max_gap)) tick();
      end
      req_a[id*DATA_W +: DATA_W] = qa[i];
      req_b[id*DATA_W +: DATA_W] = qb[i];
      req_last[sid]  = (i == qa.size() - 1);
      req_valid[sid] = 1'b1;
      if (i == 0) exp_g = model_grant(req_valid);
      n = 0;
      while (req_ready === '0 && n < 100) begin
        tick();
        n++;
      end
      if (i == 0) begin
        onehot = '0;
        onehot[exp_g[ID_W-1:0]] = 1'b1;
        check("grant", req_ready, onehot);
        model_rr = (exp_g + 1) % NUM_REQ;
      end else begin
        check("ready_hold", req_ready[sid], 1);
      end
      tick();
    end
    req_valid[sid] = 1'b0;
    req_last[sid]  = 1'b0;
  endtask

  task automatic expect_result(input int id, input int hold, input bit early);
    if (early) res_ready = 1'b1;
    check("latency_low", res_valid, 0);
    for (int k = 1; k < MULT_LAT; k++) begin
      tick();
      check("latency_low", res_valid, 0);
    end
    tick();
    check("res_valid", res_valid, 1);
    check("res_data", res_data, exp_sum);
    check("res_id", res_id, id);
    check("res_count", res_count, exp_cnt);
    check("res_ovf", res_ovf, exp_ovf);
    for (int k = 0; k < hold; k++) begin
      tick();
      check("hold_valid", res_valid, 1);
      check("hold_data", res_data, exp_sum);
      check("hold_id", res_id, id);
      check("hold_no_ready", req_ready, 0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("res_drop", res_valid, 0);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int id;
    int len;
    bit early;
    ARESET    = 1'b1;
    enable    = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b0;
    do_reset();

    qa = '{3, -4, 5};
    qb = '{7, 2, -1};
    send_vec(2, 0);
    expect_result(2, 0, 1'b0);

    qa = '{10, -20};
    qb = '{3, 3};
    send_vec(1, 0);
    expect_result(1, 5, 1'b0);

    qa = '{int'(32'h8000_0000), int'(32'h8000_0000)};
    qb = '{int'(32'h8000_0000), int'(32'h8000_0000)};
    send_vec(3, 0);
    expect_result(3, 0, 1'b0);

    do_reset();
    req_valid = '1;
    req_last  = '1;
    for (int r = 0; r < NUM_REQ; r++) begin
      id = model_grant(req_valid);
      qa = '{id + 1};
      qb = '{10};
      send_vec(id, 0);
      expect_result(id, 0, 1'b0);
    end
    req_valid = 4'b1001;
    for (int r = 0; r < 2; r++) begin
      id = model_grant(req_valid);
      qa = '{7 * (r + 1)};
      qb = '{-3};
      send_vec(id, 0);
      expect_result(id, 0, 1'b0);
    end

    req_a[1*DATA_W +: DATA_W] = 5;
    req_b[1*DATA_W +: DATA_W] = 6;
    req_last[1]  = 1'b0;
    req_valid[1] = 1'b1;
    tick();
    tick();
    tick();
    do_reset();
    req_valid = '0;
    qa = '{1, 1};
    qb = '{1, 1};
    send_vec(1, 0);
    expect_result(1, 0, 1'b0);

    enable = 1'b0;
    req_a[1*DATA_W +: DATA_W] = 4;
    req_b[1*DATA_W +: DATA_W] = 5;
    req_last[1]  = 1'b1;
    req_valid[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("disabled_busy", busy, 0);
      check("disabled_ready", req_ready, 0);
    end
    enable = 1'b1;
    tick();
    check("enable_grant", req_ready, 4'b0010);
    qa = '{4};
    qb = '{5};
    send_vec(1, 0);
    expect_result(1, 0, 1'b0);

    for (int r = 0; r < 12; r++) begin
      id  = $urandom_range(0, NUM_REQ - 1);
      len = $urandom_range(1, 6);
      qa.delete();
      qb.delete();
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 1) == 1) begin
          qa.push_back(int'($urandom));
          qb.push_back(int'($urandom));
        end else begin
          qa.push_back($urandom_range(0, 200) - 100);
          qb.push_back($urandom_range(0, 200) - 100);
        end
      end
      early = ($urandom_range(0, 1) == 1);
      send_vec(id, 3);
      expect_result(id, early ? 0 : $urandom_range(0, 3), early);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
